// File: rtl/aesha_job_ctrl.sv
// aesha_job_ctrl: host-side job sequencer for the AESHA AES/Keccak core.
// Takes one job at a time, holds the core operands stable, pulses the core
// through a reset cycle, waits for the rising edge of done (or a timeout),
// then returns the 512-bit result on a valid/ready response port.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | ready for a job; core held in reset
// LAUNCH | operands latched; core sees one reset cycle; timeout cleared
// RUN    | core running; waiting for done rising edge or timeout
// RESP   | response valid; result/err held until m_ready

module aesha_job_ctrl #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         i_clk,
    input  logic         i_reset,

    input  logic         s_valid,
    output logic         s_ready,
    input  logic         s_aes_or_keccak,
    input  logic         s_enc_or_dec,
    input  logic [127:0] s_key,
    input  logic [511:0] s_data,

    output logic         o_core_run,
    output logic         o_core_aes_or_keccak,
    output logic         o_core_enc_or_dec,
    output logic [127:0] o_core_key,
    output logic [511:0] o_core_data,
    input  logic         i_core_done,
    input  logic [511:0] i_core_data,

    output logic         m_valid,
    input  logic         m_ready,
    output logic [511:0] m_data,
    output logic         m_err,

    output logic [15:0]  o_jobs_ok,
    output logic [15:0]  o_jobs_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    logic [1:0]       state_q;
    logic             done_q;
    logic [CNT_W-1:0] tmo_cnt_q;
    logic             core_edge;
    logic             tmo_hit;

    // Handshake and core-run strobes decode directly from the state.
    assign s_ready    = (state_q == ST_IDLE);
    assign o_core_run = (state_q == ST_RUN);
    assign m_valid    = (state_q == ST_RESP);

    // A done that was already high when RUN began never produces an edge.
    assign core_edge = i_core_done & ~done_q;
    assign tmo_hit   = (tmo_cnt_q == CNT_LAST);

    // Registered copy of the core done level, tracked in every state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= i_core_done;
        end
    end

    // Job sequencing, operand latch, timeout counter and response capture.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q              <= ST_IDLE;
            tmo_cnt_q            <= '0;
            o_core_aes_or_keccak <= 1'b0;
            o_core_enc_or_dec    <= 1'b0;
            o_core_key           <= '0;
            o_core_data          <= '0;
            m_data               <= '0;
            m_err                <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (s_valid) begin
                        o_core_aes_or_keccak <= s_aes_or_keccak;
                        o_core_enc_or_dec    <= s_enc_or_dec;
                        o_core_key           <= s_key;
                        o_core_data          <= s_data;
                        state_q              <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    tmo_cnt_q <= '0;
                    state_q   <= ST_RUN;
                end
                ST_RUN: begin
                    tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
                    // A completion on the final count still counts as success.
                    if (core_edge) begin
                        m_data  <= i_core_data;
                        m_err   <= 1'b0;
                        state_q <= ST_RESP;
                    end else if (tmo_hit) begin
                        m_data  <= '0;
                        m_err   <= 1'b1;
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (m_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Completed/failed job counters, bumped on the response handshake.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_jobs_ok  <= '0;
            o_jobs_err <= '0;
        end else if (m_valid && m_ready) begin
            if (m_err) begin
                o_jobs_err <= o_jobs_err + 16'd1;
            end else begin
                o_jobs_ok <= o_jobs_ok + 16'd1;
            end
        end
    end

endmodule
